// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write arbiter.
package rf_pkg;

    localparam int NUM_REGS   = 16;
    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    function automatic logic [NUM_REGS-1:0] onehot_dec(input logic [ADDR_W-1:0] a);
        onehot_dec    = '0;
        onehot_dec[a] = 1'b1;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback requester handshakes, read-port decode and write-port bus.
interface rf_write_arbiter_if;
    import rf_pkg::*;

    logic                req0_valid;
    logic                req0_ready;
    logic [ADDR_W-1:0]   req0_addr;
    logic [DATA_W-1:0]   req0_data;
    logic                req1_valid;
    logic                req1_ready;
    logic [ADDR_W-1:0]   req1_addr;
    logic [DATA_W-1:0]   req1_data;
    logic                rd_en1;
    logic                rd_en2;
    logic [ADDR_W-1:0]   rd_addr1;
    logic [ADDR_W-1:0]   rd_addr2;
    logic [NUM_REGS-1:0] WriteReg;
    logic [DATA_W-1:0]   wr_data;
    logic [NUM_REGS-1:0] ReadEnable1;
    logic [NUM_REGS-1:0] ReadEnable2;
    logic                rd_pending1;
    logic                rd_pending2;
    logic [1:0]          wr_grant;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output rd_en1, rd_en2, rd_addr1, rd_addr2,
        input  req0_ready, req1_ready,
        input  WriteReg, wr_data, ReadEnable1, ReadEnable2,
        input  rd_pending1, rd_pending2, wr_grant
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  rd_en1, rd_en2, rd_addr1, rd_addr2,
        output req0_ready, req1_ready,
        output WriteReg, wr_data, ReadEnable1, ReadEnable2,
        output rd_pending1, rd_pending2, wr_grant
    );

endinterface

// File: rtl/rf_wb_fifo.sv
// Depth-2 writeback holding buffer; exposes per-slot valid/addr for hazard compare.
module rf_wb_fifo
    import rf_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  wb_entry_t                        push_entry,
    input  logic                             pop,
    output wb_entry_t                        head,
    output logic [1:0]                       count,
    output logic [FIFO_DEPTH-1:0]            ent_valid,
    output logic [FIFO_DEPTH-1:0][ADDR_W-1:0] ent_addr
);

    wb_entry_t             mem_q [FIFO_DEPTH];
    wb_entry_t             mem_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] valid_q, valid_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;

    // Slots fill contiguously, so the slot under wr_ptr is free whenever not full.
    always_comb begin
        mem_d    = mem_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (pop && valid_q[rd_ptr_q]) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = ~rd_ptr_q;
        end
        if (push && !valid_q[wr_ptr_q]) begin
            mem_d[wr_ptr_q]   = push_entry;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = ~wr_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        head      = mem_q[rd_ptr_q];
        count     = 2'(valid_q[0]) + 2'(valid_q[1]);
        ent_valid = valid_q;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            ent_addr[i] = mem_q[i].addr;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin sharing of the register-file write port between ALU and load
// writeback, plus read-port decode and pending-write hazard flags.
module rf_write_arbiter
    import rf_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    rf_write_arbiter_if.slave  bus
);

    wb_entry_t                         head0, head1, gnt_head;
    logic [1:0]                        count0, count1;
    logic [FIFO_DEPTH-1:0]             vld0, vld1;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0] adr0, adr1;
    logic                              rdy0, rdy1, ne0, ne1, any_gnt, pop0, pop1;
    logic                              hit1, hit2;
    req_id_t                           rr_q, rr_d, gnt_id;

    assign rdy0 = rst && (count0 != 2'(FIFO_DEPTH));
    assign rdy1 = rst && (count1 != 2'(FIFO_DEPTH));
    assign ne0  = (count0 != 2'd0);
    assign ne1  = (count1 != 2'd0);

    rf_wb_fifo u_fifo0 (
        .clk        (clk),
        .rst        (rst),
        .push       (bus.req0_valid && rdy0),
        .push_entry ('{addr: bus.req0_addr, data: bus.req0_data}),
        .pop        (pop0),
        .head       (head0),
        .count      (count0),
        .ent_valid  (vld0),
        .ent_addr   (adr0)
    );

    rf_wb_fifo u_fifo1 (
        .clk        (clk),
        .rst        (rst),
        .push       (bus.req1_valid && rdy1),
        .push_entry ('{addr: bus.req1_addr, data: bus.req1_data}),
        .pop        (pop1),
        .head       (head1),
        .count      (count1),
        .ent_valid  (vld1),
        .ent_addr   (adr1)
    );

    always_ff @(posedge clk) begin
        if (!rst) rr_q <= REQ0;
        else      rr_q <= rr_d;
    end

    // Grant is masked while reset is low so the reset edge never commits a stale entry.
    always_comb begin
        rr_d    = rr_q;
        gnt_id  = REQ0;
        any_gnt = rst && (ne0 || ne1);
        if (ne0 && ne1) begin
            gnt_id = rr_q;
            rr_d   = (rr_q == REQ0) ? REQ1 : REQ0;
        end else if (ne1) begin
            gnt_id = REQ1;
        end
    end

    always_comb begin
        pop0     = any_gnt && (gnt_id == REQ0);
        pop1     = any_gnt && (gnt_id == REQ1);
        gnt_head = (gnt_id == REQ1) ? head1 : head0;

        bus.req0_ready = rdy0;
        bus.req1_ready = rdy1;
        bus.wr_grant   = {pop1, pop0};
        bus.wr_data    = any_gnt ? gnt_head.data : '0;
        bus.WriteReg   = (any_gnt && (gnt_head.addr != '0)) ? onehot_dec(gnt_head.addr) : '0;

        bus.ReadEnable1 = bus.rd_en1 ? onehot_dec(bus.rd_addr1) : '0;
        bus.ReadEnable2 = bus.rd_en2 ? onehot_dec(bus.rd_addr2) : '0;
    end

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if ((vld0[i] && adr0[i] == bus.rd_addr1) || (vld1[i] && adr1[i] == bus.rd_addr1)) hit1 = 1'b1;
            if ((vld0[i] && adr0[i] == bus.rd_addr2) || (vld1[i] && adr1[i] == bus.rd_addr2)) hit2 = 1'b1;
        end
        bus.rd_pending1 = bus.rd_en1 && (bus.rd_addr1 != '0) && hit1;
        bus.rd_pending2 = bus.rd_en2 && (bus.rd_addr2 != '0) && hit2;
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench: queue-based reference model checked every cycle,
// decode vector table, and directed multi-cycle sequences.
module tb_rf_write_arbiter;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rf_write_arbiter_if bus ();

    rf_write_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  gnt;
        logic [15:0] we;
        logic [15:0] wd;
    } commit_t;

    typedef struct {
        logic        en1;
        logic [3:0]  a1;
        logic        en2;
        logic [3:0]  a2;
        logic [15:0] exp_re1;
        logic [15:0] exp_re2;
        logic        exp_p1;
        logic        exp_p2;
    } dec_vec_t;

    int checks = 0;
    int errors = 0;

    wb_entry_t m0[$];
    wb_entry_t m1[$];
    logic      m_rr = 1'b0;
    commit_t   log_q[$];

    logic        acc0, acc1;
    logic        s_rdy0, s_rdy1, s_p1, s_p2;
    logic [1:0]  s_gnt;
    logic [15:0] s_we, s_wd, s_re1, s_re2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: compare DUT against the model mid-cycle, then advance the model.
    task automatic tick();
        logic        e_rdy0, e_rdy1, e_p1, e_p2, h1, h2;
        logic [1:0]  g;
        wb_entry_t   h;
        logic [15:0] e_we, e_wd, e_re1, e_re2;
        @(negedge clk);
        e_rdy0 = rst && (m0.size() < 2);
        e_rdy1 = rst && (m1.size() < 2);
        if (!rst)                              g = 2'b00;
        else if (m0.size() > 0 && m1.size() > 0) g = m_rr ? 2'b10 : 2'b01;
        else if (m0.size() > 0)                g = 2'b01;
        else if (m1.size() > 0)                g = 2'b10;
        else                                   g = 2'b00;
        h = '0;
        if (g == 2'b01) h = m0[0];
        if (g == 2'b10) h = m1[0];
        e_we  = (g != 2'b00 && h.addr != 4'd0) ? (16'h0001 << h.addr) : 16'h0000;
        e_wd  = (g != 2'b00) ? h.data : 16'h0000;
        e_re1 = bus.rd_en1 ? (16'h0001 << bus.rd_addr1) : 16'h0000;
        e_re2 = bus.rd_en2 ? (16'h0001 << bus.rd_addr2) : 16'h0000;
        h1 = 1'b0;
        h2 = 1'b0;
        foreach (m0[i]) begin
            if (m0[i].addr == bus.rd_addr1) h1 = 1'b1;
            if (m0[i].addr == bus.rd_addr2) h2 = 1'b1;
        end
        foreach (m1[i]) begin
            if (m1[i].addr == bus.rd_addr1) h1 = 1'b1;
            if (m1[i].addr == bus.rd_addr2) h2 = 1'b1;
        end
        e_p1 = bus.rd_en1 && bus.rd_addr1 != 4'd0 && h1;
        e_p2 = bus.rd_en2 && bus.rd_addr2 != 4'd0 && h2;

        s_rdy0 = bus.req0_ready;  s_rdy1 = bus.req1_ready;
        s_gnt  = bus.wr_grant;    s_we   = bus.WriteReg;   s_wd = bus.wr_data;
        s_re1  = bus.ReadEnable1; s_re2  = bus.ReadEnable2;
        s_p1   = bus.rd_pending1; s_p2   = bus.rd_pending2;

        chk("req0_ready",  32'(s_rdy0), 32'(e_rdy0));
        chk("req1_ready",  32'(s_rdy1), 32'(e_rdy1));
        chk("wr_grant",    32'(s_gnt),  32'(g));
        chk("WriteReg",    32'(s_we),   32'(e_we));
        chk("wr_data",     32'(s_wd),   32'(e_wd));
        chk("ReadEnable1", 32'(s_re1),  32'(e_re1));
        chk("ReadEnable2", 32'(s_re2),  32'(e_re2));
        chk("rd_pending1", 32'(s_p1),   32'(e_p1));
        chk("rd_pending2", 32'(s_p2),   32'(e_p2));
        if (s_gnt != 2'b00) log_q.push_back('{gnt: s_gnt, we: s_we, wd: s_wd});

        @(posedge clk);
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (!rst) begin
            m0.delete();
            m1.delete();
            m_rr = 1'b0;
        end else begin
            acc0 = bus.req0_valid && e_rdy0;
            acc1 = bus.req1_valid && e_rdy1;
            if (m0.size() > 0 && m1.size() > 0) m_rr = ~m_rr;
            if (g == 2'b01) void'(m0.pop_front());
            if (g == 2'b10) void'(m1.pop_front());
            if (acc0) m0.push_back('{addr: bus.req0_addr, data: bus.req0_data});
            if (acc1) m1.push_back('{addr: bus.req1_addr, data: bus.req1_data});
        end
        #1;
    endtask

    task automatic idle_reqs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 12 && (m0.size() > 0 || m1.size() > 0); c++) tick();
        chk("drain_empty", 32'(m0.size() + m1.size()), 32'd0);
    endtask

    dec_vec_t dec_tab[6];
    logic [1:0]  c_gnt[4];
    logic [15:0] c_we[4];
    logic [15:0] c_wd[4];
    int i0, i1, n0, n1;
    logic saw_full;

    initial begin
        bus.req0_valid = 1'b1; bus.req0_addr = 4'd3; bus.req0_data = 16'h0001;
        bus.req1_valid = 1'b1; bus.req1_addr = 4'd4; bus.req1_data = 16'h0002;
        bus.rd_en1 = 1'b0; bus.rd_addr1 = '0;
        bus.rd_en2 = 1'b0; bus.rd_addr2 = '0;

        dec_tab[0] = '{1'b1, 4'd0,  1'b1, 4'd15, 16'h0001, 16'h8000, 1'b0, 1'b0};
        dec_tab[1] = '{1'b1, 4'd5,  1'b0, 4'd5,  16'h0020, 16'h0000, 1'b0, 1'b0};
        dec_tab[2] = '{1'b0, 4'd9,  1'b1, 4'd9,  16'h0000, 16'h0200, 1'b0, 1'b0};
        dec_tab[3] = '{1'b1, 4'd10, 1'b1, 4'd3,  16'h0400, 16'h0008, 1'b0, 1'b0};
        dec_tab[4] = '{1'b0, 4'd0,  1'b0, 4'd0,  16'h0000, 16'h0000, 1'b0, 1'b0};
        dec_tab[5] = '{1'b1, 4'd15, 1'b1, 4'd1,  16'h8000, 16'h0002, 1'b0, 1'b0};

        // Reset held with both requesters offering: nothing accepted, outputs quiet.
        #1;
        tick();
        tick();
        chk("rst_ready0", 32'(s_rdy0), 32'd0);
        chk("rst_ready1", 32'(s_rdy1), 32'd0);
        chk("rst_we",     32'(s_we),   32'd0);
        rst = 1'b1;
        idle_reqs();
        tick();
        chk("rel_ready0", 32'(s_rdy0), 32'd1);
        chk("rel_ready1", 32'(s_rdy1), 32'd1);
        chk("rel_grant",  32'(s_gnt),  32'd0);

        // Read decode table with empty buffers.
        foreach (dec_tab[k]) begin
            bus.rd_en1 = dec_tab[k].en1; bus.rd_addr1 = dec_tab[k].a1;
            bus.rd_en2 = dec_tab[k].en2; bus.rd_addr2 = dec_tab[k].a2;
            tick();
            chk("tab_re1", 32'(s_re1), 32'(dec_tab[k].exp_re1));
            chk("tab_re2", 32'(s_re2), 32'(dec_tab[k].exp_re2));
            chk("tab_p1",  32'(s_p1),  32'(dec_tab[k].exp_p1));
            chk("tab_p2",  32'(s_p2),  32'(dec_tab[k].exp_p2));
        end
        bus.rd_en1 = 1'b0;
        bus.rd_en2 = 1'b0;

        // Single uncontested write.
        bus.req0_valid = 1'b1; bus.req0_addr = 4'd5; bus.req0_data = 16'hBEEF;
        tick();
        idle_reqs();
        tick();
        chk("single_we",  32'(s_we),  32'h0020);
        chk("single_wd",  32'(s_wd),  32'hBEEF);
        chk("single_gnt", 32'(s_gnt), 32'h1);
        tick();
        chk("single_idle_gnt", 32'(s_gnt), 32'h0);
        chk("single_idle_we",  32'(s_we),  32'h0);

        // Contention: r0 R1,R2 and r1 R3,R4 commit as R1,R3,R2,R4.
        log_q.delete();
        bus.req0_valid = 1'b1; bus.req0_addr = 4'd1; bus.req0_data = 16'h1111;
        bus.req1_valid = 1'b1; bus.req1_addr = 4'd3; bus.req1_data = 16'h3333;
        tick();
        bus.req0_addr = 4'd2; bus.req0_data = 16'h2222;
        bus.req1_addr = 4'd4; bus.req1_data = 16'h4444;
        tick();
        idle_reqs();
        drain();
        tick();
        c_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
        c_we  = '{16'h0002, 16'h0008, 16'h0004, 16'h0010};
        c_wd  = '{16'h1111, 16'h3333, 16'h2222, 16'h4444};
        chk("cont_count", 32'(log_q.size()), 32'd4);
        for (int k = 0; k < 4 && k < log_q.size(); k++) begin
            chk("cont_gnt", 32'(log_q[k].gnt), 32'(c_gnt[k]));
            chk("cont_we",  32'(log_q[k].we),  32'(c_we[k]));
            chk("cont_wd",  32'(log_q[k].wd),  32'(c_wd[k]));
        end

        // Backpressure: r0 pushes 3 back-to-back against streaming r1 traffic.
        log_q.delete();
        i0 = 0; i1 = 0; saw_full = 1'b0;
        for (int c = 0; c < 30 && (i0 < 3 || i1 < 4); c++) begin
            bus.req0_valid = (i0 < 3); bus.req0_addr = 4'd2; bus.req0_data = 16'hA000 + 16'(i0);
            bus.req1_valid = (i1 < 4); bus.req1_addr = 4'd9; bus.req1_data = 16'hB000 + 16'(i1);
            tick();
            if (!s_rdy0) saw_full = 1'b1;
            if (acc0) i0++;
            if (acc1) i1++;
        end
        idle_reqs();
        drain();
        chk("bp_sent0", 32'(i0), 32'd3);
        chk("bp_sent1", 32'(i1), 32'd4);
        chk("bp_saw_full", 32'(saw_full), 32'd1);
        n0 = 0; n1 = 0;
        foreach (log_q[k]) begin
            if (log_q[k].gnt == 2'b01) begin
                chk("bp_r0_data", 32'(log_q[k].wd), 32'(16'hA000 + 16'(n0)));
                chk("bp_r0_we",   32'(log_q[k].we), 32'h0004);
                n0++;
            end else begin
                chk("bp_r1_data", 32'(log_q[k].wd), 32'(16'hB000 + 16'(n1)));
                n1++;
            end
        end
        chk("bp_r0_commits", 32'(n0), 32'd3);
        chk("bp_r1_commits", 32'(n1), 32'd4);

        // Address-0 drop, then pending hazard on a buffered write.
        bus.req0_valid = 1'b1; bus.req0_addr = 4'd0; bus.req0_data = 16'h1234;
        tick();
        idle_reqs();
        bus.rd_en2 = 1'b1; bus.rd_addr2 = 4'd0;
        tick();
        chk("r0_gnt",     32'(s_gnt), 32'h1);
        chk("r0_we",      32'(s_we),  32'h0);
        chk("r0_pend2",   32'(s_p2),  32'h0);
        chk("r0_re2",     32'(s_re2), 32'h0001);
        tick();
        chk("r0_consumed", 32'(s_gnt), 32'h0);
        bus.req1_valid = 1'b1; bus.req1_addr = 4'd7; bus.req1_data = 16'h7777;
        bus.rd_en1 = 1'b1; bus.rd_addr1 = 4'd7;
        bus.rd_addr2 = 4'd3;
        tick();
        chk("pend_before", 32'(s_p1),  32'h0);
        chk("pend_re1",    32'(s_re1), 32'h0080);
        idle_reqs();
        tick();
        chk("pend_commit", 32'(s_p1),  32'h1);
        chk("pend_we",     32'(s_we),  32'h0080);
        chk("pend_gnt",    32'(s_gnt), 32'h2);
        chk("pend_other",  32'(s_p2),  32'h0);
        tick();
        chk("pend_after",  32'(s_p1),  32'h0);
        bus.rd_en1 = 1'b0;
        bus.rd_en2 = 1'b0;

        // Reset mid-operation discards buffered writes and clears rr.
        bus.req0_valid = 1'b1; bus.req0_addr = 4'd11; bus.req0_data = 16'hC000;
        bus.req1_valid = 1'b1; bus.req1_addr = 4'd12; bus.req1_data = 16'hD000;
        tick();
        bus.req0_data = 16'hC001; bus.req1_data = 16'hD001;
        tick();
        idle_reqs();
        log_q.delete();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        chk("midrst_no_commit", 32'(log_q.size()), 32'd0);
        chk("midrst_ready0",    32'(s_rdy0), 32'd1);
        bus.req0_valid = 1'b1; bus.req0_addr = 4'd6; bus.req0_data = 16'h6060;
        bus.req1_valid = 1'b1; bus.req1_addr = 4'd8; bus.req1_data = 16'h8080;
        tick();
        idle_reqs();
        tick();
        chk("midrst_rr_gnt", 32'(s_gnt), 32'h1);
        chk("midrst_rr_wd",  32'(s_wd),  32'h6060);
        drain();

        // Random traffic against the model.
        for (int c = 0; c < 80; c++) begin
            bus.req0_valid = 1'($urandom_range(0, 1));
            bus.req0_addr  = 4'($urandom_range(0, 15));
            bus.req0_data  = 16'($urandom);
            bus.req1_valid = 1'($urandom_range(0, 1));
            bus.req1_addr  = 4'($urandom_range(0, 15));
            bus.req1_data  = 16'($urandom);
            bus.rd_en1     = 1'($urandom_range(0, 1));
            bus.rd_addr1   = 4'($urandom_range(0, 15));
            bus.rd_en2     = 1'($urandom_range(0, 1));
            bus.rd_addr2   = 4'($urandom_range(0, 15));
            tick();
        end
        idle_reqs();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
